// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha round sequencer.
package chacha_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StQrIssue,
    StQrWait,
    StFf,
    StDone
  } state_e;

  localparam int unsigned QR_PER_DR   = 8;
  localparam int unsigned STATE_WORDS = 16;
  // State word incremented by ctr_inc at the end of each block.
  localparam int unsigned CTR_WORD    = 12;

endpackage

// File: rtl/chacha_qr_index.sv
// Quarter-round operand index decode: q[1:0] selects the lane, q[2] selects
// column (0) or diagonal (1) rounds.
module chacha_qr_index (
  input  logic [2:0] q,
  output logic [3:0] idx_a,
  output logic [3:0] idx_b,
  output logic [3:0] idx_c,
  output logic [3:0] idx_d
);

  logic [1:0] lane;
  logic       diag;

  // Each row is rotated by k, 2k and 3k lanes; 2-bit adds give the mod-4 wrap.
  always_comb begin
    lane  = q[1:0];
    diag  = q[2];
    idx_a = {2'b00, lane};
    idx_b = {2'b01, lane + {1'b0, diag}};
    idx_c = {2'b10, lane + {diag, 1'b0}};
    idx_d = {2'b11, lane + {diag, diag}};
  end

endmodule

// File: rtl/chacha_round_sequencer.sv
// Control FSM for the shared ChaCha quarter-round datapath: issues the
// column/diagonal quarter-rounds, walks the feed-forward add, then pulses
// done together with the block-counter increment.
module chacha_round_sequencer
  import chacha_pkg::*;
#(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       qr_done,
  output logic       busy,
  output logic       qr_go,
  output logic [3:0] qr_idx_a,
  output logic [3:0] qr_idx_b,
  output logic [3:0] qr_idx_c,
  output logic [3:0] qr_idx_d,
  output logic       ff_en,
  output logic [3:0] ff_idx,
  output logic       done,
  output logic       ctr_inc
);

  localparam logic [2:0] QLast  = 3'(QR_PER_DR - 1);
  localparam logic [3:0] RLast  = 4'(DOUBLE_ROUNDS - 1);
  localparam logic [3:0] FfLast = 4'(STATE_WORDS - 1);

  state_e     state_q;
  logic [2:0] qr_cnt_q;
  logic [3:0] dr_cnt_q;
  logic [2:0] q_issue;
  logic [3:0] nxt_a, nxt_b, nxt_c, nxt_d;

  // Quarter-round number of the next issue; the 3-bit wrap restarts at 0
  // for a new double round, and IDLE always starts at 0.
  always_comb begin
    q_issue = (state_q == StQrWait) ? qr_cnt_q + 3'd1 : 3'd0;
  end

  chacha_qr_index u_qr_index (
    .q     (q_issue),
    .idx_a (nxt_a),
    .idx_b (nxt_b),
    .idx_c (nxt_c),
    .idx_d (nxt_d)
  );

  // State, counters and registered outputs; abort shares the reset path so
  // it wins over start and qr_done.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state_q  <= StIdle;
      qr_cnt_q <= '0;
      dr_cnt_q <= '0;
      busy     <= 1'b0;
      qr_go    <= 1'b0;
      qr_idx_a <= '0;
      qr_idx_b <= '0;
      qr_idx_c <= '0;
      qr_idx_d <= '0;
      ff_en    <= 1'b0;
      ff_idx   <= '0;
      done     <= 1'b0;
      ctr_inc  <= 1'b0;
    end else begin
      qr_go   <= 1'b0;
      done    <= 1'b0;
      ctr_inc <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StQrIssue;
            busy     <= 1'b1;
            qr_go    <= 1'b1;
            qr_cnt_q <= '0;
            dr_cnt_q <= '0;
            qr_idx_a <= nxt_a;
            qr_idx_b <= nxt_b;
            qr_idx_c <= nxt_c;
            qr_idx_d <= nxt_d;
          end
        end
        StQrIssue: begin
          state_q <= StQrWait;
        end
        StQrWait: begin
          if (qr_done) begin
            if (qr_cnt_q < QLast || dr_cnt_q < RLast) begin
              state_q  <= StQrIssue;
              qr_go    <= 1'b1;
              qr_cnt_q <= q_issue;
              if (qr_cnt_q == QLast) begin
                dr_cnt_q <= dr_cnt_q + 4'd1;
              end
              qr_idx_a <= nxt_a;
              qr_idx_b <= nxt_b;
              qr_idx_c <= nxt_c;
              qr_idx_d <= nxt_d;
            end else begin
              state_q  <= StFf;
              qr_cnt_q <= '0;
              dr_cnt_q <= '0;
              ff_en    <= 1'b1;
              ff_idx   <= '0;
              qr_idx_a <= '0;
              qr_idx_b <= '0;
              qr_idx_c <= '0;
              qr_idx_d <= '0;
            end
          end
        end
        StFf: begin
          if (ff_idx == FfLast) begin
            state_q <= StDone;
            ff_en   <= 1'b0;
            ff_idx  <= '0;
            done    <= 1'b1;
            ctr_inc <= 1'b1;
          end else begin
            ff_idx <= ff_idx + 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_round_sequencer.sv
// Self-checking bench for chacha_round_sequencer: a 10-double-round DUT driven
// by a variable-latency QR model, plus a 4-double-round DUT for the short build.
`timescale 1ns/1ps
module tb_chacha_round_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, start4;
  logic       qr_done, qr_done_m = 1'b0, qr_done_x = 1'b0, qr_done4 = 1'b0;
  logic       busy, qr_go, ff_en, done, ctr_inc;
  logic [3:0] qr_idx_a, qr_idx_b, qr_idx_c, qr_idx_d, ff_idx;
  logic       busy4, qr_go4, ff_en4, done4, ctr_inc4;
  logic [3:0] a4, b4, c4, d4, ff_idx4;

  int checks = 0, failures = 0, cyc = 0, lat = 1, cnt = 0;
  int go_cnt = 0, done_cnt = 0, go4 = 0;
  bit mon_en = 1'b0, inject_en = 1'b0;
  logic [15:0] qr_q[$];
  logic [3:0]  ff_q[$];
  logic [15:0] hold_idx = '0, mon_exp, cur_idx, cur4;
  logic [3:0]  ff_exp;
  logic [24:0] outs;

  assign qr_done = qr_done_m | qr_done_x;
  assign cur_idx = {qr_idx_a, qr_idx_b, qr_idx_c, qr_idx_d};
  assign cur4    = {a4, b4, c4, d4};
  assign outs    = {busy, qr_go, cur_idx, ff_en, ff_idx, done, ctr_inc};

  chacha_round_sequencer #(.DOUBLE_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .qr_done(qr_done),
    .busy(busy), .qr_go(qr_go), .qr_idx_a(qr_idx_a), .qr_idx_b(qr_idx_b),
    .qr_idx_c(qr_idx_c), .qr_idx_d(qr_idx_d), .ff_en(ff_en), .ff_idx(ff_idx),
    .done(done), .ctr_inc(ctr_inc)
  );

  chacha_round_sequencer #(.DOUBLE_ROUNDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(1'b0), .qr_done(qr_done4),
    .busy(busy4), .qr_go(qr_go4), .qr_idx_a(a4), .qr_idx_b(b4),
    .qr_idx_c(c4), .qr_idx_d(d4), .ff_en(ff_en4), .ff_idx(ff_idx4),
    .done(done4), .ctr_inc(ctr_inc4)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // QR unit model: qr_done pulses lat cycles after each qr_go.
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 0;
      qr_done_m <= 1'b0;
    end else begin
      qr_done_m <= 1'b0;
      if (qr_go) begin
        if (lat == 1) qr_done_m <= 1'b1;
        else cnt <= lat - 1;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) qr_done_m <= 1'b1;
      end
    end
  end

  // Stray qr_done during QR_ISSUE and FF cycles.
  always @(negedge clk) qr_done_x <= inject_en && (qr_go || ff_en);

  always @(posedge clk) qr_done4 <= qr_go4;

  function automatic logic [15:0] exp_tuple(input int q);
    case (q)
      0: return {4'd0, 4'd4, 4'd8,  4'd12};
      1: return {4'd1, 4'd5, 4'd9,  4'd13};
      2: return {4'd2, 4'd6, 4'd10, 4'd14};
      3: return {4'd3, 4'd7, 4'd11, 4'd15};
      4: return {4'd0, 4'd5, 4'd10, 4'd15};
      5: return {4'd1, 4'd6, 4'd11, 4'd12};
      6: return {4'd2, 4'd7, 4'd8,  4'd13};
      default: return {4'd3, 4'd4, 4'd9, 4'd14};
    endcase
  endfunction

  // Scoreboard monitor for the main DUT.
  always @(negedge clk) begin
    if (mon_en) begin
      if (qr_go) begin
        checks++;
        go_cnt++;
        if (qr_q.size() == 0) begin
          failures++;
          $display("FAIL qr_go_extra: got idx %h, required no qr_go", cur_idx);
        end else begin
          mon_exp = qr_q.pop_front();
          if (cur_idx !== mon_exp) begin
            failures++;
            $display("FAIL qr_idx_order: got %h, required %h", cur_idx, mon_exp);
          end
        end
        hold_idx = cur_idx;
      end else if (busy && !ff_en && !done) begin
        checks++;
        if (cur_idx !== hold_idx) begin
          failures++;
          $display("FAIL qr_idx_hold: got %h, required %h", cur_idx, hold_idx);
        end
      end
      if (ff_en) begin
        checks++;
        if (ff_q.size() == 0) begin
          failures++;
          $display("FAIL ff_extra: got ff_idx %0d, required no ff_en", ff_idx);
        end else begin
          ff_exp = ff_q.pop_front();
          if (ff_idx !== ff_exp) begin
            failures++;
            $display("FAIL ff_idx_order: got %0d, required %0d", ff_idx, ff_exp);
          end
        end
      end
      if (!busy) begin
        checks++;
        if (outs !== 25'd0) begin
          failures++;
          $display("FAIL idle_outputs: got %h, required 0", outs);
        end
      end
      checks++;
      if (done !== ctr_inc) begin
        failures++;
        $display("FAIL done_ctr_inc: got done=%b ctr_inc=%b, required equal", done, ctr_inc);
      end
      if (done) done_cnt++;
    end
  end

  // Index order check for the 4-double-round DUT.
  always @(negedge clk) begin
    if (mon_en && qr_go4) begin
      checks++;
      if (cur4 !== exp_tuple(go4 % 8)) begin
        failures++;
        $display("FAIL dr4_idx: got %h, required %h", cur4, exp_tuple(go4 % 8));
      end
      go4++;
    end
  end

  task automatic push_block(input int dr);
    for (int r = 0; r < dr; r++)
      for (int q = 0; q < 8; q++) qr_q.push_back(exp_tuple(q));
    for (int f = 0; f < 16; f++) ff_q.push_back(4'(f));
  endtask

  task automatic flush();
    qr_q.delete();
    ff_q.delete();
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        at = cyc;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (outs !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    checks++;
    if ({busy4, qr_go4, ff_en4, done4, ctr_inc4} !== 5'd0) begin
      failures++;
      $display("FAIL reset_outputs_dr4: got %b, required 0",
               {busy4, qr_go4, ff_en4, done4, ctr_inc4});
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    // abort and start together in IDLE: abort wins
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_start_idle: got busy=%b, required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_block(input int l, input bit inject);
    int t0, at, g0;
    lat = l;
    inject_en = inject;
    g0 = go_cnt;
    push_block(10);
    pulse_start(t0);
    wait_done(2000, at);
    checks++;
    if (at - t0 != 1 + 80 * (1 + l) + 16) begin
      failures++;
      $display("FAIL block_latency_l%0d: got %0d, required %0d", l, at - t0, 1 + 80 * (1 + l) + 16);
    end
    checks++;
    if (go_cnt - g0 != 80) begin
      failures++;
      $display("FAIL qr_go_count_l%0d: got %0d, required 80", l, go_cnt - g0);
    end
    @(negedge clk);
    inject_en = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_done: got %b, required 0", busy);
    end
    checks++;
    if (qr_q.size() + ff_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left: got %0d entries, required 0", qr_q.size() + ff_q.size());
    end
  endtask

  task automatic test_abort(input bit on_wait);
    int t0, at, n, dc;
    lat = 1;
    n = 0;
    push_block(10);
    pulse_start(t0);
    for (int i = 0; i < 500; i++) begin
      if (qr_go === 1'b1) begin
        n++;
        if (n == 37) break;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 37) begin
      failures++;
      $display("FAIL abort_reach_go37: got %0d, required 37", n);
    end
    if (on_wait) @(negedge clk);
    dc = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    flush();
    checks++;
    if (outs !== 25'd0) begin
      failures++;
      $display("FAIL abort_outputs_w%0d: got %h, required 0", on_wait, outs);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != dc) begin
      failures++;
      $display("FAIL abort_no_done: got %0d dones, required 0", done_cnt - dc);
    end
    push_block(10);
    pulse_start(t0);
    wait_done(500, at);
    checks++;
    if (at - t0 != 177) begin
      failures++;
      $display("FAIL abort_restart_latency: got %0d, required 177", at - t0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t0, at, g, at2;
    lat = 1;
    g = -1;
    push_block(10);
    pulse_start(t0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (44) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (110) @(negedge clk);
    start = 1'b1;  // held through FF and DONE
    wait_done(500, at);
    push_block(10);
    checks++;
    if (at - t0 != 177) begin
      failures++;
      $display("FAIL busy_start_latency: got %0d, required 177", at - t0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (qr_go === 1'b1) begin
        g = cyc;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (g - at != 2) begin
      failures++;
      $display("FAIL held_start_gap: got %0d, required 2", g - at);
    end
    wait_done(500, at2);
    checks++;
    if (at2 - (at + 1) != 177) begin
      failures++;
      $display("FAIL second_block_latency: got %0d, required 177", at2 - (at + 1));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_ff();
    int t0, n;
    bit hit;
    lat = 1;
    hit = 1'b0;
    push_block(10);
    pulse_start(t0);
    for (int i = 0; i < 500; i++) begin
      if (ff_en === 1'b1 && ff_idx === 4'd7) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL reach_ff7: got no ff_idx 7, required ff_idx 7");
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    flush();
    checks++;
    if (outs !== 25'd0) begin
      failures++;
      $display("FAIL reset_in_ff_outputs: got %h, required 0", outs);
    end
    @(negedge clk);
    n = 0;
  endtask

  task automatic test_dr4();
    int t0, at, g0;
    g0 = go4;
    at = -1;
    start4 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done4 === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (at - t0 != 81) begin
      failures++;
      $display("FAIL dr4_latency: got %0d, required 81", at - t0);
    end
    checks++;
    if (go4 - g0 != 32) begin
      failures++;
      $display("FAIL dr4_qr_go_count: got %0d, required 32", go4 - g0);
    end
    checks++;
    if (ctr_inc4 !== 1'b1) begin
      failures++;
      $display("FAIL dr4_ctr_inc: got %b, required 1", ctr_inc4);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_block(1, 1'b0);
    test_block(3, 1'b0);
    test_block(2, 1'b1);
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    test_reset_in_ff();
    test_dr4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
